// File: rtl/multiword_add_seq.sv
//------------------------------------------------------------------------------
// multiword_add_seq
//
// Sequential multi-word adder front end. Operands arrive one 32-bit word pair
// per beat, least-significant word first. Each beat goes through a
// combinational carry-skip adder (carry_skip_32bit). The adder carry-out is
// held between beats so that the carry chains across the words of an
// operation. Every sum word is presented on a single registered
// valid/ready output stage.
//
// Optional feature macro: MWADD_OVF_EN
//   defined   : out_ovf reports signed overflow of the whole operation and is
//               registered with the final word.
//   undefined : out_ovf is tied to 0 and no overflow logic is built.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input word-pair handshake
//   in_a, in_b          32-bit operand words
//   in_cin              carry-in, used only on a beat with in_first=1
//   in_first, in_last   least/most significant word markers
//   out_valid/out_ready output handshake
//   out_sum             32-bit sum word
//   out_idx             word index within the operation (0 = LSW)
//   out_last            final word of the operation
//   out_cout            carry out of this word
//   out_ovf             signed overflow of the operation (with out_last only)
//   out_err             protocol error attached to this word
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module carry_skip_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    // Eight 4-bit ripple blocks. When every bit of a block propagates, the
    // block carry-in bypasses the ripple chain straight to the next block.
    logic w_blk_c;
    logic w_rip_c;
    logic w_all_p;
    logic w_p;

    always_comb begin
        sum     = '0;
        w_blk_c = cin;
        w_rip_c = 1'b0;
        w_all_p = 1'b0;
        w_p     = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            w_rip_c = w_blk_c;
            w_all_p = 1'b1;
            for (int k = 0; k < 4; k++) begin
                w_p                = a[4*blk+k] ^ b[4*blk+k];
                sum[4*blk+k]       = w_p ^ w_rip_c;
                w_rip_c            = (a[4*blk+k] & b[4*blk+k]) | (w_p & w_rip_c);
                w_all_p            = w_all_p & w_p;
            end
            w_blk_c = w_all_p ? w_blk_c : w_rip_c;
        end
        cout = w_blk_c;
    end
endmodule

module multiword_add_seq #(
    parameter int MAX_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_cin,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_err
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;

    logic             w_acc;
    logic             w_cin_sel;
    logic [31:0]      w_sum;
    logic             w_cout;
    logic [IDX_W-1:0] w_word_idx;
    logic             w_force_last;
    logic             w_last_eff;
    logic             w_err;

    // Single output register without a skid buffer: a new word can only be
    // taken when the register is empty or being drained this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign w_acc     = in_valid && in_ready;
    assign w_cin_sel = in_first ? in_cin : r_carry;

    carry_skip_32bit u_add (
        .a    (in_a),
        .b    (in_b),
        .cin  (w_cin_sel),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_word_idx   = r_idx;
        w_force_last = 1'b0;
        w_last_eff   = 1'b0;
        w_err        = 1'b0;

        // A first word, or a stray word arriving outside an operation,
        // always restarts numbering at 0.
        if (in_first || (r_state == S_IDLE)) begin
            w_word_idx = '0;
        end

        // Word MAX_WORDS-1 without in_last is forcibly terminated.
        w_force_last = (w_word_idx == IDX_W'(MAX_WORDS - 1)) && !in_last;
        w_last_eff   = in_last || w_force_last;
        w_err        = ((r_state == S_IDLE) && !in_first) ||
                       ((r_state == S_RUN)  &&  in_first) ||
                       w_force_last;

        if (w_acc) begin
            w_state_nxt = w_last_eff ? S_IDLE : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry   <= 1'b0;
            r_idx     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
        end else if (w_acc) begin
            // The carry and index do not survive past the end of an operation.
            r_carry   <= w_last_eff ? 1'b0 : w_cout;
            r_idx     <= w_last_eff ? '0 : (w_word_idx + 1'b1);
            out_valid <= 1'b1;
            out_sum   <= w_sum;
            out_idx   <= w_word_idx;
            out_last  <= w_last_eff;
            out_cout  <= w_cout;
            out_err   <= w_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MWADD_OVF_EN
    logic w_ovf;

    // Signed overflow: operands share a sign that the top sum word does not.
    assign w_ovf = w_last_eff && (in_a[31] == in_b[31]) && (w_sum[31] != in_a[31]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (w_acc) begin
            out_ovf <= w_ovf;
        end
    end
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
`timescale 1ns/1ps

module tb_multiword_add_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_cout;
    logic        out_ovf;
    logic        out_err;

`ifdef MWADD_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    multiword_add_seq #(.MAX_WORDS(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit rnd_on = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        first;
        logic        last;
        logic [31:0] e_sum;
        logic [2:0]  e_idx;
        logic        e_last;
        logic        e_cout;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    vec_t        vt[$];
    logic [39:0] exp_q[$];

    // Packed view: {valid, sum, idx, last, cout, ovf, err}
    function automatic logic [39:0] pk(input logic v, input logic [31:0] s, input logic [2:0] idx,
                                       input logic l, input logic c, input logic o, input logic e);
        return {v, s, idx, l, c, o, e};
    endfunction

    function automatic logic [39:0] cur();
        return {out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, out_err};
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic f, input logic l, input logic [31:0] es,
                                input logic [2:0] ei, input logic el, input logic ec,
                                input logic eo, input logic ee);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.first = f; v.last = l;
        v.e_sum = es; v.e_idx = ei; v.e_last = el; v.e_cout = ec; v.e_ovf = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic f, input logic l);
        in_valid = v; in_a = a; in_b = b; in_cin = cin; in_first = f; in_last = l;
    endtask

    // Reference: whole operation as wide integers; each word's carry-out is the
    // carry into the next word's bit 0, recovered as s ^ a ^ b at that bit.
    task automatic model_op(input int len, input logic [31:0] wa[8], input logic [31:0] wb[8],
                            input logic cin);
        bit [287:0] A, B, S;
        logic       c;
        logic       o;
        A = '0; B = '0;
        for (int i = 0; i < len; i++) begin
            A[32*i +: 32] = wa[i];
            B[32*i +: 32] = wb[i];
        end
        S = A + B + 288'(cin);
        for (int i = 0; i < len; i++) begin
            c = S[32*(i+1)] ^ A[32*(i+1)] ^ B[32*(i+1)];
            o = 1'b0;
            if (i == len - 1)
                o = OVF & (wa[i][31] == wb[i][31]) & (S[32*i+31] != wa[i][31]);
            exp_q.push_back(pk(1'b1, S[32*i +: 32], 3'(i), i == len - 1, c, o, 1'b0));
        end
    endtask

    always @(negedge clk) begin
        if (rnd_on && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_extra: got %h expected none", cur());
            end else begin
                chk("rand_word", cur(), exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rword();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return 32'hFFFF_FFFF;
        if (sel == 1) return 32'h0;
        return $urandom;
    endfunction

    initial begin
        logic [31:0] wa[8];
        logic [31:0] wb[8];
        logic        rc;
        int          len;
        int          guard;

        // ---- reset state ----
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_outputs", cur(), 40'h0);
        chk("reset_in_ready", 40'(in_ready), 40'd1);
        #29 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- reset in the middle of a 3-word operation ----
        drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("midop_w0", cur(), pk(1'b1, 32'h3333_3333, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 32'h4444_4444, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #5 rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", cur(), 40'h0);
        chk("midop_reset_in_ready", 40'(in_ready), 40'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- table-driven vectors ----
        vt.push_back(mk(32'h1, 32'h2, 0, 1, 1, 32'h3, 0, 1, 0, 0, 0));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h1, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0));
        vt.push_back(mk(32'h0, 32'h0, 0, 0, 1, 32'h1, 1, 1, 0, 0, 0));
        vt.push_back(mk(32'h7FFF_FFFF, 32'h1, 0, 1, 1, 32'h8000_0000, 0, 1, 0, OVF, 0));
        vt.push_back(mk(32'h5, 32'h6, 1, 1, 0, 32'hC, 0, 0, 0, 0, 0));
        vt.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1, 32'hFFFF_FFFE, 0, 1, 1, 0, 1));
        vt.push_back(mk(32'h10, 32'h20, 1, 0, 0, 32'h30, 0, 0, 0, 0, 1));
        vt.push_back(mk(32'h0, 32'h0, 0, 0, 1, 32'h0, 1, 1, 0, 0, 0));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h0, 1, 1, 0, 32'h0, 0, 0, 1, 0, 0));
        for (int i = 1; i < 7; i++)
            vt.push_back(mk(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 32'h0, 3'(i), 0, 1, 0, 0));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 32'h0, 7, 1, 1, 0, 1));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1));
        vt.push_back(mk(32'h0, 32'h0, 0, 0, 1, 32'h0, 1, 1, 0, 0, 0));
        vt.push_back(mk(32'h8000_0000, 32'h8000_0000, 0, 1, 1, 32'h0, 0, 1, 1, OVF, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].first, vt[i].last);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), cur(),
                pk(1'b1, vt[i].e_sum, vt[i].e_idx, vt[i].e_last, vt[i].e_cout, vt[i].e_ovf, vt[i].e_err));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("drain_valid", 40'(out_valid), 40'd0);

        // ---- back-pressure on a 3-word stream ----
        drive(1'b1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("bp_w0", cur(), pk(1'b1, 32'h1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        out_ready = 1'b0;
        drive(1'b1, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_in_ready%0d", i), 40'(in_ready), 40'd0);
            chk($sformatf("bp_hold%0d", i), cur(), pk(1'b1, 32'h1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_w1", cur(), pk(1'b1, 32'h10, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("bp_w2", cur(), pk(1'b1, 32'h0, 3'd2, 1'b1, 1'b1, OVF, 1'b0));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("bp_drain", 40'(out_valid), 40'd0);

        // ---- randomized well-formed operations ----
        rnd_on = 1'b1;
        for (int op = 0; op < 150; op++) begin
            len = $urandom_range(1, 8);
            rc  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                wa[i] = rword();
                wb[i] = rword();
            end
            model_op(len, wa, wb, rc);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                drive(1'b1, wa[i], wb[i], rc, i == 0, i == len - 1);
                guard = 0;
                forever begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (in_ready) begin
                        @(posedge clk); #1;
                        break;
                    end
                    @(posedge clk); #1;
                    guard++;
                    if (guard > 100) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL rand_in_ready_timeout: got in_ready 0 expected 1");
                        break;
                    end
                end
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_outstanding: got %0d words left expected 0", exp_q.size());
        end
        rnd_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
